// File: rtl/ram_lfsr_checker.sv
// ram_lfsr_checker
// Read-side memory test engine. On a start request it reads every RAM address
// in ascending order. It regenerates the 8-bit LFSR fill pattern locally and
// compares each returned word against it. It reports the mismatch count, the
// first failing address and a pass/fail verdict.
//
// Ports:
//   CLK_I            clock, all logic on the rising edge
//   RST_I            synchronous active-high reset
//   START_I          one-cycle start request (ignored while busy)
//   RD_EN_O          RAM read enable (registered)
//   RD_ADDR_O        RAM read address (registered)
//   RD_DATA_I        RAM read data, valid RD_LATENCY cycles after the read
//   BUSY_O           sweep in progress
//   DONE_O           result valid, held until the next accepted start or reset
//   PASS_O           DONE_O with zero mismatches
//   ERR_CNT_O        mismatch count (ADDR_W+1 bits, so it cannot overflow)
//   FIRST_ERR_ADDR_O address of the first mismatch in the sweep (0 if none)
//   ERR_O            one-cycle pulse per mismatching word
module ram_lfsr_checker #(
  parameter int          ADDR_W     = 8,
  parameter int          RD_LATENCY = 1,
  parameter logic [7:0]  SEED       = 8'hFF
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              START_I,
  output logic              RD_EN_O,
  output logic [ADDR_W-1:0] RD_ADDR_O,
  input  logic [7:0]        RD_DATA_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic              PASS_O,
  output logic [ADDR_W:0]   ERR_CNT_O,
  output logic [ADDR_W-1:0] FIRST_ERR_ADDR_O,
  output logic              ERR_O
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1'b1);

  // One step of the fill-pattern LFSR (taps 7,5,4,3, shifting left).
  function automatic logic [7:0] f_lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [1:0]            r_state;
  logic                  r_rd_en;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [ADDR_W:0]       r_err_cnt;
  logic [ADDR_W-1:0]     r_first_err_addr;
  logic                  r_err;
  logic [RD_LATENCY-1:0] r_tag;
  logic [7:0]            r_exp;
  logic [ADDR_W-1:0]     r_cmp_addr;

  logic                  w_start;
  logic                  w_cmp;
  logic                  w_mismatch;
  logic                  w_last_issue;
  logic                  w_last_cmp;
  logic [ADDR_W:0]       w_err_cnt_nxt;

  // A start is only accepted when no sweep is running.
  assign w_start      = START_I && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // Read data is valid exactly when the tag of its read leaves the pipeline.
  assign w_cmp        = r_tag[RD_LATENCY-1];
  assign w_mismatch   = w_cmp && (RD_DATA_I != r_exp);
  assign w_last_issue = (r_rd_addr == ADDR_LAST);
  assign w_last_cmp   = w_cmp && (r_cmp_addr == ADDR_LAST);

  // Mismatch count including the compare happening this cycle, so the
  // verdict taken on the final compare already sees the final count.
  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (w_mismatch) begin
      w_err_cnt_nxt = r_err_cnt + CNT_ONE;
    end else begin
      w_err_cnt_nxt = r_err_cnt;
    end
  end

  // Sweep control FSM: read issue, drain of outstanding reads, result hold.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state   <= ST_IDLE;
      r_rd_en   <= 1'b0;
      r_rd_addr <= ADDR_ZERO;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state   <= ST_ISSUE;
            r_rd_en   <= 1'b1;
            r_rd_addr <= ADDR_ZERO;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (w_last_issue) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DRAIN: begin
          if (w_last_cmp) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_cnt_nxt == CNT_ZERO);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline that tracks outstanding reads; reset flushes it so reads
  // issued before a reset never produce a compare.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_tag <= {RD_LATENCY{1'b0}};
    end else begin
      r_tag[0] <= r_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Compare datapath: expected pattern, compare address and error results.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_exp            <= SEED;
      r_cmp_addr       <= ADDR_ZERO;
      r_err_cnt        <= CNT_ZERO;
      r_first_err_addr <= ADDR_ZERO;
      r_err            <= 1'b0;
    end else begin
      r_err <= w_mismatch;
      if (w_start) begin
        // No reads are outstanding when a start is accepted.
        r_exp            <= SEED;
        r_cmp_addr       <= ADDR_ZERO;
        r_err_cnt        <= CNT_ZERO;
        r_first_err_addr <= ADDR_ZERO;
      end else if (w_cmp) begin
        r_exp      <= f_lfsr_next(r_exp);
        r_cmp_addr <= r_cmp_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        r_err_cnt  <= w_err_cnt_nxt;
        // A zero count before this compare means this is the first mismatch.
        if (w_mismatch && (r_err_cnt == CNT_ZERO)) begin
          r_first_err_addr <= r_cmp_addr;
        end
      end
    end
  end

  assign RD_EN_O          = r_rd_en;
  assign RD_ADDR_O        = r_rd_addr;
  assign BUSY_O           = r_busy;
  assign DONE_O           = r_done;
  assign PASS_O           = r_pass;
  assign ERR_CNT_O        = r_err_cnt;
  assign FIRST_ERR_ADDR_O = r_first_err_addr;
  assign ERR_O            = r_err;

endmodule
